// File: rtl/riscv_fetch_pkg.sv
// Shared constants, fetch-entry payload and PC helper for the instruction fetch stage.
package riscv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries; clear overrides push and pop.
module fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              push,
    input  fetch_entry_t                      push_data,
    input  logic                              pop,
    input  logic                              clear,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(QDEPTH > 1 ? QDEPTH : 2):0] count,
    output fetch_entry_t                      head
);

    localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    r_mem [QDEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == CW'(QDEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];

    assign w_do_push = push & ~full & ~clear;
    assign w_do_pop  = pop & ~empty & ~clear;

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word requests and presents one instruction per cycle to decode.
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    input  logic        id_ready_in,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        flush_out
);

    localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic [31:0]   w_fetch_pc_nxt;
    logic [31:0]   w_resp_pc_nxt;
    logic [CW-1:0] w_discard_nxt;
    logic [CW-1:0] w_outstanding_nxt;
    logic [31:0]   w_target;
    logic [CW:0]   w_credit_sum;
    logic          w_grant;
    logic          w_rvalid;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;

    logic          w_q_full;
    logic          w_q_empty;
    logic [CW-1:0] w_q_count;
    fetch_entry_t  w_q_head;
    fetch_entry_t  w_q_wdata;

    assign w_target     = align_word(redirect_pc_in);
    assign w_credit_sum = {1'b0, w_q_count} + {1'b0, r_outstanding};

    // Queued plus in-flight words never exceed the queue depth, so a response always has room.
    assign imem_req_out  = ~rst_in & ~redirect_in & ~w_q_full
                         & (w_credit_sum < (CW+1)'(QDEPTH));
    assign imem_addr_out = r_fetch_pc;

    assign w_grant = imem_req_out & imem_gnt_in;
    // A response with nothing in flight is a protocol error and is ignored.
    assign w_rvalid = imem_rvalid_in & (r_outstanding != '0);
    assign w_drop   = w_rvalid & (r_discard != '0);
    assign w_push   = w_rvalid & ~w_drop & ~redirect_in;
    assign w_pop    = ~w_q_empty & id_ready_in & ~redirect_in;

    assign w_outstanding_nxt = r_outstanding + CW'(w_grant) - CW'(w_rvalid);

    assign w_q_wdata.pc    = r_resp_pc;
    assign w_q_wdata.instr = imem_rdata_in;

    // Next-state for PCs and discard count; a redirect overrides normal advancement.
    always_comb begin
        w_fetch_pc_nxt = r_fetch_pc;
        w_resp_pc_nxt  = r_resp_pc;
        w_discard_nxt  = r_discard;
        if (redirect_in) begin
            w_fetch_pc_nxt = w_target;
            w_resp_pc_nxt  = w_target;
            w_discard_nxt  = w_outstanding_nxt;
        end else begin
            if (w_grant) begin
                w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
            end
            if (w_push) begin
                w_resp_pc_nxt = r_resp_pc + PC_STEP;
            end
            if (w_drop) begin
                w_discard_nxt = r_discard - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_fetch_pc    <= align_word(RESET_PC);
            r_resp_pc     <= align_word(RESET_PC);
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_resp_pc     <= w_resp_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (w_push),
        .push_data (w_q_wdata),
        .pop       (w_pop),
        .clear     (redirect_in),
        .full      (w_q_full),
        .empty     (w_q_empty),
        .count     (w_q_count),
        .head      (w_q_head)
    );

    assign instr_valid_out = ~w_q_empty;
    assign instr_out       = w_q_empty ? NOP_INSTR : w_q_head.instr;
    assign pc_out          = w_q_empty ? 32'h0000_0000 : w_q_head.pc;
    assign flush_out       = w_q_empty | redirect_in;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, fixed-latency instruction memory model.
module tb_instr_fetch_unit;

    logic        clk_in;
    logic        rst_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        id_ready_in;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        flush_out;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] glog[$];
    logic [31:0] dlog[$];
    int          cyc = 0;
    int          lat = 1;
    int          mdl_outstanding = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .imem_req_out    (imem_req_out),
        .imem_addr_out   (imem_addr_out),
        .imem_gnt_in     (imem_gnt_in),
        .imem_rvalid_in  (imem_rvalid_in),
        .imem_rdata_in   (imem_rdata_in),
        .redirect_in     (redirect_in),
        .redirect_pc_in  (redirect_pc_in),
        .id_ready_in     (id_ready_in),
        .instr_valid_out (instr_valid_out),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .flush_out       (flush_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Memory: always grants, answers in order after lat cycles; word content is 0xC000_0000 | address.
    initial begin
        imem_gnt_in    = 1'b1;
        imem_rvalid_in = 1'b0;
        imem_rdata_in  = 32'h0;
        forever begin
            @(posedge clk_in);
            if (rst_in) begin
                pend.delete();
                mdl_outstanding = 0;
            end else begin
                if (imem_rvalid_in) begin
                    assert (mdl_outstanding > 0) else $error("rvalid with nothing outstanding");
                    mdl_outstanding--;
                end
                if (imem_req_out && imem_gnt_in) begin
                    pend.push_back('{addr: imem_addr_out, due: cyc + lat});
                    glog.push_back(imem_addr_out);
                    mdl_outstanding++;
                end
            end
            cyc++;
            #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid_in = 1'b1;
                imem_rdata_in  = 32'hC000_0000 | pend[0].addr;
                void'(pend.pop_front());
            end else begin
                imem_rvalid_in = 1'b0;
                imem_rdata_in  = 32'h0;
            end
        end
    end

    // Record every PC handed to decode.
    initial begin
        forever begin
            @(posedge clk_in);
            if (!rst_in && instr_valid_out && id_ready_in && !redirect_in)
                dlog.push_back(pc_out);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    function automatic logic [31:0] dlog_at(input int i);
        return (dlog.size() > i) ? dlog[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] glog_at(input int i);
        return (glog.size() > i) ? glog[i] : 32'hDEAD_BEEF;
    endfunction

    // Hold reset two cycles, then release; the caller is in the first post-reset cycle.
    task automatic reset_and_release(input int latency, input logic ready);
        rst_in         = 1'b1;
        redirect_in    = 1'b0;
        redirect_pc_in = 32'h0;
        id_ready_in    = ready;
        lat            = latency;
        tick();
        tick();
        rst_in = 1'b0;
        dlog.delete();
        glog.delete();
        #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!instr_valid_out && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_valid_in_time"}, 32'(instr_valid_out), 32'd1);
    endtask

    initial begin
        rst_in         = 1'b1;
        redirect_in    = 1'b0;
        redirect_pc_in = 32'h0;
        id_ready_in    = 1'b1;

        // Reset values and streaming start with 1-cycle memory.
        tick();
        tick();
        check_eq("rst_req",   32'(imem_req_out),    32'd0);
        check_eq("rst_valid", 32'(instr_valid_out), 32'd0);
        check_eq("rst_instr", instr_out,            32'h0000_0013);
        check_eq("rst_pc",    pc_out,               32'h0);
        check_eq("rst_flush", 32'(flush_out),       32'd1);
        rst_in = 1'b0;
        dlog.delete();
        #1;
        check_eq("c0_req",  32'(imem_req_out), 32'd1);
        check_eq("c0_addr", imem_addr_out,     32'h0);
        tick();
        check_eq("c1_req",   32'(imem_req_out),    32'd1);
        check_eq("c1_addr",  imem_addr_out,        32'h4);
        check_eq("c1_valid", 32'(instr_valid_out), 32'd0);
        tick();
        check_eq("c2_valid", 32'(instr_valid_out), 32'd1);
        check_eq("c2_pc",    pc_out,               32'h0);
        check_eq("c2_instr", instr_out,            32'hC000_0000);
        check_eq("c2_flush", 32'(flush_out),       32'd0);
        tick();
        check_eq("c3_valid", 32'(instr_valid_out), 32'd1);
        check_eq("c3_pc",    pc_out,               32'h4);
        check_eq("c3_instr", instr_out,            32'hC000_0004);
        repeat (10) tick();
        check_eq("stream_d0", dlog_at(0), 32'h0);
        check_eq("stream_d1", dlog_at(1), 32'h4);
        check_eq("stream_d2", dlog_at(2), 32'h8);
        check_eq("stream_d3", dlog_at(3), 32'hC);

        // Decode stall fills the queue, then release resumes at 0x8.
        reset_and_release(1, 1'b0);
        repeat (6) tick();
        check_eq("stall_req",   32'(imem_req_out),    32'd0);
        check_eq("stall_valid", 32'(instr_valid_out), 32'd1);
        check_eq("stall_pc",    pc_out,               32'h0);
        tick();
        check_eq("stall_hold_pc",    pc_out,    32'h0);
        check_eq("stall_hold_instr", instr_out, 32'hC000_0000);
        id_ready_in = 1'b1;
        tick();
        check_eq("resume_req",  32'(imem_req_out), 32'd1);
        check_eq("resume_addr", imem_addr_out,     32'h8);
        repeat (12) tick();
        check_eq("resume_d0", dlog_at(0), 32'h0);
        check_eq("resume_d1", dlog_at(1), 32'h4);
        check_eq("resume_d2", dlog_at(2), 32'h8);
        check_eq("resume_d3", dlog_at(3), 32'hC);
        check_eq("resume_d4", dlog_at(4), 32'h10);

        // Redirect with two requests in flight on a 3-cycle memory.
        reset_and_release(3, 1'b1);
        tick();
        tick();
        redirect_in    = 1'b1;
        redirect_pc_in = 32'h0000_0103;
        glog.delete();
        #1;
        check_eq("rd2_flush", 32'(flush_out),    32'd1);
        check_eq("rd2_req",   32'(imem_req_out), 32'd0);
        tick();
        redirect_in = 1'b0;
        check_eq("rd2_valid_next", 32'(instr_valid_out), 32'd0);
        wait_valid("rd2", 20);
        check_eq("rd2_first_pc",    pc_out,    32'h100);
        check_eq("rd2_first_instr", instr_out, 32'hC000_0100);
        repeat (4) tick();
        check_eq("rd2_grant0", glog_at(0), 32'h100);
        check_eq("rd2_d0",     dlog_at(0), 32'h100);
        check_eq("rd2_d1",     dlog_at(1), 32'h104);

        // Redirect coinciding with a response and a pop.
        reset_and_release(1, 1'b1);
        tick();
        tick();
        check_eq("rdp_pre_valid", 32'(instr_valid_out), 32'd1);
        check_eq("rdp_pre_rv",    32'(imem_rvalid_in),  32'd1);
        redirect_in    = 1'b1;
        redirect_pc_in = 32'h0000_0040;
        dlog.delete();
        #1;
        check_eq("rdp_flush", 32'(flush_out), 32'd1);
        tick();
        redirect_in = 1'b0;
        #1;
        check_eq("rdp_valid_next", 32'(instr_valid_out), 32'd0);
        check_eq("rdp_req",        32'(imem_req_out),    32'd1);
        check_eq("rdp_addr",       imem_addr_out,        32'h40);
        tick();
        check_eq("rdp_valid_r2", 32'(instr_valid_out), 32'd0);
        tick();
        check_eq("rdp_valid_r3", 32'(instr_valid_out), 32'd1);
        check_eq("rdp_pc",       pc_out,               32'h40);
        check_eq("rdp_instr",    instr_out,            32'hC000_0040);
        repeat (3) tick();
        check_eq("rdp_d0", dlog_at(0), 32'h40);

        // Two redirects back to back; the second target wins.
        reset_and_release(1, 1'b1);
        repeat (5) tick();
        redirect_in    = 1'b1;
        redirect_pc_in = 32'h0000_0200;
        dlog.delete();
        glog.delete();
        #1;
        check_eq("rr_flush0", 32'(flush_out), 32'd1);
        tick();
        redirect_pc_in = 32'h0000_0300;
        #1;
        check_eq("rr_flush1", 32'(flush_out),       32'd1);
        check_eq("rr_req1",   32'(imem_req_out),    32'd0);
        check_eq("rr_valid1", 32'(instr_valid_out), 32'd0);
        tick();
        redirect_in = 1'b0;
        repeat (10) tick();
        check_eq("rr_grant0", glog_at(0), 32'h300);
        check_eq("rr_d0",     dlog_at(0), 32'h300);
        check_eq("rr_d1",     dlog_at(1), 32'h304);

        // Reset while the queue is full.
        reset_and_release(1, 1'b0);
        repeat (6) tick();
        check_eq("mr_pre_valid", 32'(instr_valid_out), 32'd1);
        check_eq("mr_pre_req",   32'(imem_req_out),    32'd0);
        rst_in = 1'b1;
        tick();
        check_eq("mr_valid", 32'(instr_valid_out), 32'd0);
        check_eq("mr_instr", instr_out,            32'h0000_0013);
        check_eq("mr_pc",    pc_out,               32'h0);
        check_eq("mr_flush", 32'(flush_out),       32'd1);
        check_eq("mr_req",   32'(imem_req_out),    32'd0);
        rst_in = 1'b0;
        #1;
        check_eq("mr_restart_req",  32'(imem_req_out), 32'd1);
        check_eq("mr_restart_addr", imem_addr_out,     32'h0);
        tick();
        check_eq("mr_restart_addr1", imem_addr_out, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
